video_output_pipe: RTL and testbench
====================================

VIDEO_OUTPUT_PIPE -- requirements
Module: video_output_pipe

Interface
REQ-001 Parameters SHALL be, one per line:
- CW, 6, input colour width per component, legal range 3..8.
- OW, 6, output colour width per component, legal range 4..8.
- LATENCY, 4, fixed pipeline depth; this value is the only legal one.
REQ-002 Ports SHALL be, one per line:
- clk_sys  in  1  master clock.
- reset_n  in  1  asynchronous active-low reset.
- ce_pix  in  1  pixel enable; all inputs are sampled only when it is high.
- r_in/g_in/b_in  in  CW each  colour components.
- hs_in/vs_in  in  1 each  positive-pulse syncs.
- hblank/vblank  in  1 each  blanking.
- scanlines  in  2  darkening level: 0 none, 1 25%, 2 50%, 3 75%.
- scan_phase  in  1  selects which line parity is darkened.
- ypbpr  in  1  selects YPbPr output.
- ypbpr_full  in  1  selects 0-255 range instead of 16-235/240.
- csync  in  1  selects composite sync.
- r_out/g_out/b_out  out  OW each  colour components.
- hs_out/vs_out  out  1 each  active-low syncs.
- de_out  out  1  data enable.

Function
REQ-003 The pipeline SHALL advance only on clk_sys cycles with ce_pix=1 and SHALL hold all stage registers otherwise.
REQ-004 Latency SHALL be exactly 4 ce_pix cycles from inputs to outputs for colour, sync and de. The RGB path SHALL also take 4 cycles.
REQ-005 Stage 1 SHALL widen each component to 8 bits by MSB replication (CW=6: 63 -> 255). It SHALL force colour to 0 when hblank or vblank is high.
REQ-006 A line-parity flag SHALL toggle on each hs_in falling edge. It SHALL load scan_phase on each vs_in falling edge.
REQ-007 When the flag is 1, stage 1 SHALL attenuate each component as follows:
- Level 1: v>>1 + v>>2.
- Level 2: v>>1.
- Level 3: v>>2.
When the flag is 0, or at level 0, it SHALL pass the value unchanged.
REQ-008 The scanlines, ypbpr, ypbpr_full and csync inputs SHALL be captured into shadow registers only on the vs_in falling edge. The datapath SHALL use only the shadow copies.
REQ-009 Stage 2 SHALL form the 8x8 coefficient products. Stage 3 SHALL compute the following, each result >>8 and 17-bit signed intermediate:
- Y = 4096 + 66R + 129G + 25B.
- Pb = 32768 - 38R - 74G + 112B.
- Pr = 32768 + 112R - 94G - 18B.
REQ-010 Stage 3 SHALL clamp Y to 16..235 and Pb/Pr to 16..240.
REQ-011 Stage 4 SHALL apply full-range expansion when ypbpr_full=1:
- Y' = ((Y-16)*298+128)>>8.
- C' = ((C-16)*291+128)>>8.
- Each result saturates at 255.
REQ-012 The output component mapping SHALL be:
- r_out = Pr when ypbpr=1, R otherwise.
- g_out = Y when ypbpr=1, G otherwise.
- b_out = Pb when ypbpr=1, B otherwise.
- Each output is truncated to its top OW bits.
REQ-013 Sync output SHALL follow the mode:
- csync=1 or ypbpr=1: hs_out = ~(hs^vs) and vs_out = 1.
- Otherwise: hs_out = ~hs and vs_out = ~vs.
- hs and vs here are the 4-stage-delayed syncs.
REQ-014 de_out SHALL be the 4-stage-delayed ~(hblank|vblank).
REQ-015 When hs_in and vs_in fall on the same ce_pix cycle, the load from REQ-006 SHALL win over the toggle.

Reset
REQ-016 While reset_n=0, all of the following SHALL be 0:
- r_out, g_out and b_out.
- de_out.
- The line flag.
- All shadow registers.
REQ-017 While reset_n=0, hs_out and vs_out SHALL be 1.
REQ-018 Reset asserted mid-line SHALL clear all pipeline stages immediately. After release, outputs SHALL be valid after 4 ce_pix cycles.

Structure
REQ-019 The following SHALL live in package video_pkg:
- The coefficient constants.
- The clamp limits.
- The scanline level enum.
REQ-020 The single sub-module SHALL be rgb2ypbpr: stages 2-3 plus clamp, fixed latency 2.

Verification
REQ-021 CW=6, RGB mode, input 63/63/63 on a non-darkened line -> output 63/63/63 after exactly 4 ce_pix; ce_pix gaps hold the data.
REQ-022 YPbPr limited, input 255/255/255 -> Y=235, Pb=Pr=128. With OW=6 this gives g_out=58 and r_out=b_out=32.
REQ-023 YPbPr limited, input 255/0/0 -> Y=81, Pb=90, Pr=239. With ypbpr_full the expected Y' is 76.
REQ-024 Level 2, white input, scan_phase=0 -> every second line outputs 127 per component (8-bit view); level 1 gives 190.
REQ-025 Toggle ypbpr mid-frame -> the output mode changes only after the next vs_in fall.
REQ-026 Assert reset_n for 1 cycle mid-line -> outputs at reset values at once; de_out returns 4 ce_pix cycles later.

Source files
------------

// File: rtl/video_output_pipe_pkg.sv
// rtl/video_output_pipe_pkg.sv - shared constants, types and helpers for the video output pipe
package video_pkg;

   // BT.601 coefficient magnitudes; signs are applied in the summation
   localparam logic [7:0] C_Y_R  = 8'd66;
   localparam logic [7:0] C_Y_G  = 8'd129;
   localparam logic [7:0] C_Y_B  = 8'd25;
   localparam logic [7:0] C_PB_R = 8'd38;
   localparam logic [7:0] C_PB_G = 8'd74;
   localparam logic [7:0] C_PB_B = 8'd112;
   localparam logic [7:0] C_PR_R = 8'd112;
   localparam logic [7:0] C_PR_G = 8'd94;
   localparam logic [7:0] C_PR_B = 8'd18;

   localparam logic signed [16:0] OFS_Y = 17'sd4096;
   localparam logic signed [16:0] OFS_C = 17'sd32768;

   // limited-range clamp limits
   localparam logic [7:0] Y_MIN = 8'd16;
   localparam logic [7:0] Y_MAX = 8'd235;
   localparam logic [7:0] C_MIN = 8'd16;
   localparam logic [7:0] C_MAX = 8'd240;

   // full-range expansion gains (x/256)
   localparam logic [8:0] K_FULL_Y = 9'd298;
   localparam logic [8:0] K_FULL_C = 9'd291;

   typedef enum logic [1:0] {
      SCAN_OFF   = 2'd0,
      SCAN_DIM25 = 2'd1,
      SCAN_DIM50 = 2'd2,
      SCAN_DIM75 = 2'd3
   } scan_lvl_e;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       hs;
      logic       vs;
      logic       de;
   } pix_t;

   // take the integer part (bits 16:8) of a fixed-point sum and clamp it
   function automatic logic [7:0] clamp8(input logic signed [16:0] s,
                                         input logic [7:0] lo, input logic [7:0] hi);
      logic signed [8:0] v;
      logic [7:0]        o;
      v = s[16:8];
      if (v < $signed({1'b0, lo}))      o = lo;
      else if (v > $signed({1'b0, hi})) o = hi;
      else                              o = v[7:0];
      return o;
   endfunction

   // ((c-16)*k+128)>>8 saturated to 255; c is already clamped to >= 16
   function automatic logic [7:0] expand_full(input logic [7:0] c, input logic [8:0] k);
      logic [17:0] t;
      logic [7:0]  o;
      t = 18'(c - 8'd16) * 18'(k) + 18'd128;
      if (t[17:16] != 2'b00) o = 8'hFF;
      else                   o = t[15:8];
      return o;
   endfunction

endpackage

// File: rtl/video_output_pipe_if.sv
// rtl/video_output_pipe_if.sv - pixel, control and output bundle of the video output pipe
interface video_output_pipe_if #(
   parameter int CW = 6,
   parameter int OW = 6
);
   logic          ce_pix;
   logic [CW-1:0] r_in;
   logic [CW-1:0] g_in;
   logic [CW-1:0] b_in;
   logic          hs_in;
   logic          vs_in;
   logic          hblank;
   logic          vblank;
   logic [1:0]    scanlines;
   logic          scan_phase;
   logic          ypbpr;
   logic          ypbpr_full;
   logic          csync;
   logic [OW-1:0] r_out;
   logic [OW-1:0] g_out;
   logic [OW-1:0] b_out;
   logic          hs_out;
   logic          vs_out;
   logic          de_out;

   modport master (
      output ce_pix, r_in, g_in, b_in, hs_in, vs_in, hblank, vblank,
             scanlines, scan_phase, ypbpr, ypbpr_full, csync,
      input  r_out, g_out, b_out, hs_out, vs_out, de_out
   );

   modport slave (
      input  ce_pix, r_in, g_in, b_in, hs_in, vs_in, hblank, vblank,
             scanlines, scan_phase, ypbpr, ypbpr_full, csync,
      output r_out, g_out, b_out, hs_out, vs_out, de_out
   );
endinterface

// File: rtl/video_output_pipe_rgb2ypbpr.sv
// rtl/video_output_pipe_rgb2ypbpr.sv - two-stage RGB to limited-range YPbPr converter
module rgb2ypbpr
   import video_pkg::*;
(
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       ce_i,
   input  logic [7:0] r_i,
   input  logic [7:0] g_i,
   input  logic [7:0] b_i,
   output logic [7:0] y_o,
   output logic [7:0] pb_o,
   output logic [7:0] pr_o
);
   logic [15:0]        prod_d [9];
   logic [15:0]        prod_q [9];
   logic signed [16:0] y_sum, pb_sum, pr_sum;
   logic [7:0]         y_d, pb_d, pr_d;
   logic [7:0]         y_q, pb_q, pr_q;

   function automatic logic signed [16:0] sx(input logic [15:0] p);
      return $signed({1'b0, p});
   endfunction

   // coefficient products: Y row, Pb row, Pr row
   always_comb begin
      prod_d[0] = 16'(r_i) * 16'(C_Y_R);
      prod_d[1] = 16'(g_i) * 16'(C_Y_G);
      prod_d[2] = 16'(b_i) * 16'(C_Y_B);
      prod_d[3] = 16'(r_i) * 16'(C_PB_R);
      prod_d[4] = 16'(g_i) * 16'(C_PB_G);
      prod_d[5] = 16'(b_i) * 16'(C_PB_B);
      prod_d[6] = 16'(r_i) * 16'(C_PR_R);
      prod_d[7] = 16'(g_i) * 16'(C_PR_G);
      prod_d[8] = 16'(b_i) * 16'(C_PR_B);
   end

   // offset sums, integer part taken and clamped to the limited range
   always_comb begin
      y_sum  = OFS_Y + sx(prod_q[0]) + sx(prod_q[1]) + sx(prod_q[2]);
      pb_sum = OFS_C - sx(prod_q[3]) - sx(prod_q[4]) + sx(prod_q[5]);
      pr_sum = OFS_C + sx(prod_q[6]) - sx(prod_q[7]) - sx(prod_q[8]);
      y_d    = clamp8(y_sum,  Y_MIN, Y_MAX);
      pb_d   = clamp8(pb_sum, C_MIN, C_MAX);
      pr_d   = clamp8(pr_sum, C_MIN, C_MAX);
   end

   // product stage then sum/clamp stage, both advancing on the pixel enable
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 9; i++) prod_q[i] <= '0;
         y_q  <= '0;
         pb_q <= '0;
         pr_q <= '0;
      end else if (ce_i) begin
         for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
         y_q  <= y_d;
         pb_q <= pb_d;
         pr_q <= pr_d;
      end
   end

   assign y_o  = y_q;
   assign pb_o = pb_q;
   assign pr_o = pr_q;
endmodule

// File: rtl/video_output_pipe.sv
// rtl/video_output_pipe.sv - four-stage video output pipe: scanlines, optional YPbPr, sync shaping
module video_output_pipe
   import video_pkg::*;
#(
   parameter int CW      = 6,
   parameter int OW      = 6,
   parameter int LATENCY = 4
) (
   input logic                clk_sys,
   input logic                reset_n,
   video_output_pipe_if.slave vid
);
   if (LATENCY != 4 || CW < 3 || CW > 8 || OW < 4 || OW > 8) begin : g_bad_param
      $error("video_output_pipe: unsupported CW/OW/LATENCY");
   end

   // MSB replication so full scale maps to 255
   function automatic logic [7:0] widen(input logic [CW-1:0] v);
      logic [7:0] w;
      for (int i = 0; i < 8; i++) w[7-i] = v[CW-1-(i%CW)];
      return w;
   endfunction

   function automatic logic [7:0] shade(input logic [7:0] v, input logic dark,
                                        input scan_lvl_e lvl);
      logic [7:0] o;
      o = v;
      if (dark) begin
         case (lvl)
            SCAN_DIM25: o = (v >> 1) + (v >> 2);
            SCAN_DIM50: o = v >> 1;
            SCAN_DIM75: o = v >> 2;
            default:    o = v;
         endcase
      end
      return o;
   endfunction

   logic      hs_prev_q, vs_prev_q;
   logic      hs_fall, vs_fall;
   logic      line_flag_q, line_flag_d;
   scan_lvl_e scan_sh_q;
   logic      ypbpr_sh_q, full_sh_q, csync_sh_q;

   pix_t       s1_d, s1_q, s2_q, s3_q;
   logic [7:0] y_c, pb_c, pr_c;
   logic [7:0] y_f, pb_f, pr_f;
   logic [7:0] oc_r, oc_g, oc_b;
   logic       hs_d, vs_d, sync_comp;

   logic [OW-1:0] r_out_q, g_out_q, b_out_q;
   logic          hs_out_q, vs_out_q, de_out_q;

   assign hs_fall = hs_prev_q & ~vid.hs_in;
   assign vs_fall = vs_prev_q & ~vid.vs_in;

   // line parity: a frame-start load takes precedence over the per-line toggle
   always_comb begin
      line_flag_d = line_flag_q;
      if (vs_fall)      line_flag_d = vid.scan_phase;
      else if (hs_fall) line_flag_d = ~line_flag_q;
   end

   // sync edge history, line flag and per-frame shadow copies of the mode controls
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         hs_prev_q   <= 1'b0;
         vs_prev_q   <= 1'b0;
         line_flag_q <= 1'b0;
         scan_sh_q   <= SCAN_OFF;
         ypbpr_sh_q  <= 1'b0;
         full_sh_q   <= 1'b0;
         csync_sh_q  <= 1'b0;
      end else if (vid.ce_pix) begin
         hs_prev_q   <= vid.hs_in;
         vs_prev_q   <= vid.vs_in;
         line_flag_q <= line_flag_d;
         if (vs_fall) begin
            scan_sh_q  <= scan_lvl_e'(vid.scanlines);
            ypbpr_sh_q <= vid.ypbpr;
            full_sh_q  <= vid.ypbpr_full;
            csync_sh_q <= vid.csync;
         end
      end
   end

   // stage 1: widen, darken alternate lines, blank
   always_comb begin
      s1_d    = '0;
      s1_d.de = ~(vid.hblank | vid.vblank);
      s1_d.hs = vid.hs_in;
      s1_d.vs = vid.vs_in;
      if (s1_d.de) begin
         s1_d.r = shade(widen(vid.r_in), line_flag_q, scan_sh_q);
         s1_d.g = shade(widen(vid.g_in), line_flag_q, scan_sh_q);
         s1_d.b = shade(widen(vid.b_in), line_flag_q, scan_sh_q);
      end
   end

   // stage 1 register and the RGB/sync/de delay line matching the converter
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else if (vid.ce_pix) begin
         s1_q <= s1_d;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   rgb2ypbpr u_csc (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .ce_i    (vid.ce_pix),
      .r_i     (s1_q.r),
      .g_i     (s1_q.g),
      .b_i     (s1_q.b),
      .y_o     (y_c),
      .pb_o    (pb_c),
      .pr_o    (pr_c)
   );

   // stage 4: optional full-range expansion, output mapping and sync mode
   always_comb begin
      y_f       = full_sh_q ? expand_full(y_c,  K_FULL_Y) : y_c;
      pb_f      = full_sh_q ? expand_full(pb_c, K_FULL_C) : pb_c;
      pr_f      = full_sh_q ? expand_full(pr_c, K_FULL_C) : pr_c;
      oc_r      = ypbpr_sh_q ? pr_f : s3_q.r;
      oc_g      = ypbpr_sh_q ? y_f  : s3_q.g;
      oc_b      = ypbpr_sh_q ? pb_f : s3_q.b;
      sync_comp = csync_sh_q | ypbpr_sh_q;
      hs_d      = sync_comp ? ~(s3_q.hs ^ s3_q.vs) : ~s3_q.hs;
      vs_d      = sync_comp ? 1'b1 : ~s3_q.vs;
   end

   // output register; syncs idle high
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_out_q  <= '0;
         g_out_q  <= '0;
         b_out_q  <= '0;
         hs_out_q <= 1'b1;
         vs_out_q <= 1'b1;
         de_out_q <= 1'b0;
      end else if (vid.ce_pix) begin
         r_out_q  <= oc_r[7 -: OW];
         g_out_q  <= oc_g[7 -: OW];
         b_out_q  <= oc_b[7 -: OW];
         hs_out_q <= hs_d;
         vs_out_q <= vs_d;
         de_out_q <= s3_q.de;
      end
   end

   assign vid.r_out  = r_out_q;
   assign vid.g_out  = g_out_q;
   assign vid.b_out  = b_out_q;
   assign vid.hs_out = hs_out_q;
   assign vid.vs_out = vs_out_q;
   assign vid.de_out = de_out_q;
endmodule

// File: tb/tb_video_output_pipe.sv
// tb/tb_video_output_pipe.sv - scoreboard bench for video_output_pipe (CW=6, OW=6)
module tb_video_output_pipe;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   video_output_pipe_if #(.CW(6), .OW(6)) vif ();

   video_output_pipe #(.CW(6), .OW(6), .LATENCY(4)) dut (
      .clk_sys (clk),
      .reset_n (rst_n),
      .vid     (vif)
   );

   typedef struct {
      int r;
      int g;
      int b;
      bit hs;
      bit vs;
      bit de;
   } ent_t;

   ent_t sb[$];
   int   n_total = 0;
   int   n_pass  = 0;

   bit m_flag, m_hs_prev, m_vs_prev, m_ypbpr, m_full, m_csync;
   int m_scan;
   int e_r, e_g, e_b;
   bit e_hs, e_vs, e_de;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".r"},  32'(vif.r_out),  32'(e_r));
      check({tag, ".g"},  32'(vif.g_out),  32'(e_g));
      check({tag, ".b"},  32'(vif.b_out),  32'(e_b));
      check({tag, ".hs"}, 32'(vif.hs_out), 32'(e_hs));
      check({tag, ".vs"}, 32'(vif.vs_out), 32'(e_vs));
      check({tag, ".de"}, 32'(vif.de_out), 32'(e_de));
   endtask

   function automatic int widen6(int v);
      return ((v << 2) | (v >> 4)) & 255;
   endfunction

   function automatic int dim(int v, bit f, int lvl);
      if (!f) return v;
      case (lvl)
         1: return (v / 2) + (v / 4);
         2: return v / 2;
         3: return v / 4;
         default: return v;
      endcase
   endfunction

   function automatic int clampi(int v, int lo, int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   function automatic int fullx(int c, int k);
      int t;
      t = ((c - 16) * k + 128) / 256;
      return (t > 255) ? 255 : t;
   endfunction

   task automatic model_clear();
      ent_t z;
      z = '{0, 0, 0, 1'b0, 1'b0, 1'b0};
      sb.delete();
      repeat (3) sb.push_back(z);
      m_flag = 0; m_hs_prev = 0; m_vs_prev = 0;
      m_ypbpr = 0; m_full = 0; m_csync = 0; m_scan = 0;
      e_r = 0; e_g = 0; e_b = 0; e_hs = 1; e_vs = 1; e_de = 0;
   endtask

   // one clock; on an enabled cycle the stimulus enters the scoreboard and the oldest entry leaves
   task automatic step(input bit ce, input string tag);
      ent_t e, o;
      int   yv, pbv, prv;
      vif.ce_pix = ce;
      if (ce) begin
         e.de = !(vif.hblank || vif.vblank);
         e.r  = e.de ? dim(widen6(int'(vif.r_in)), m_flag, m_scan) : 0;
         e.g  = e.de ? dim(widen6(int'(vif.g_in)), m_flag, m_scan) : 0;
         e.b  = e.de ? dim(widen6(int'(vif.b_in)), m_flag, m_scan) : 0;
         e.hs = vif.hs_in;
         e.vs = vif.vs_in;
         sb.push_back(e);
         if (sb.size() >= 4) begin
            o   = sb.pop_front();
            yv  = clampi((4096 + 66 * o.r + 129 * o.g + 25 * o.b) / 256, 16, 235);
            pbv = clampi((32768 - 38 * o.r - 74 * o.g + 112 * o.b) / 256, 16, 240);
            prv = clampi((32768 + 112 * o.r - 94 * o.g - 18 * o.b) / 256, 16, 240);
            if (m_full) begin
               yv  = fullx(yv, 298);
               pbv = fullx(pbv, 291);
               prv = fullx(prv, 291);
            end
            if (m_ypbpr) begin
               e_r = prv / 4; e_g = yv / 4; e_b = pbv / 4;
            end else begin
               e_r = o.r / 4; e_g = o.g / 4; e_b = o.b / 4;
            end
            if (m_csync || m_ypbpr) begin
               e_hs = !(o.hs ^ o.vs); e_vs = 1'b1;
            end else begin
               e_hs = !o.hs; e_vs = !o.vs;
            end
            e_de = o.de;
         end
         if (m_vs_prev && !vif.vs_in) begin
            m_flag  = vif.scan_phase;
            m_scan  = int'(vif.scanlines);
            m_ypbpr = vif.ypbpr;
            m_full  = vif.ypbpr_full;
            m_csync = vif.csync;
         end else if (m_hs_prev && !vif.hs_in) begin
            m_flag = !m_flag;
         end
         m_hs_prev = vif.hs_in;
         m_vs_prev = vif.vs_in;
      end
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic pix(input int r, input int g, input int b, input bit hs = 0,
                      input bit vs = 0, input bit hb = 0, input bit vb = 0);
      vif.r_in = 6'(r); vif.g_in = 6'(g); vif.b_in = 6'(b);
      vif.hs_in = hs; vif.vs_in = vs; vif.hblank = hb; vif.vblank = vb;
      step(1'b1, "pix");
   endtask

   // disabled cycles with garbage on every input; nothing may be sampled
   task automatic idle(input int n);
      repeat (n) begin
         vif.r_in = 6'($urandom); vif.g_in = 6'($urandom); vif.b_in = 6'($urandom);
         vif.hs_in = 1'($urandom); vif.vs_in = 1'($urandom);
         vif.hblank = 1'($urandom); vif.vblank = 1'($urandom);
         step(1'b0, "hold");
      end
   endtask

   task automatic vsync();
      pix(0, 0, 0, 0, 1, 1, 1);
      pix(0, 0, 0, 0, 0, 1, 1);
   endtask

   task automatic hsync();
      pix(0, 0, 0, 1, 0, 1, 0);
   endtask

   task automatic white(input int n);
      repeat (n) pix(63, 63, 63);
   endtask

   task automatic do_reset();
      vif.ce_pix = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst.r", 32'(vif.r_out), 0);
      check("rst.g", 32'(vif.g_out), 0);
      check("rst.b", 32'(vif.b_out), 0);
      check("rst.de", 32'(vif.de_out), 0);
      check("rst.hs", 32'(vif.hs_out), 1);
      check("rst.vs", 32'(vif.vs_out), 1);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      check_outputs("post_rst");
   endtask

   task automatic random_run(input int n, input bit syncs);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         pix($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
             syncs ? ($urandom_range(0, 5) == 0) : 1'b0,
             syncs ? ($urandom_range(0, 9) == 0) : 1'b0,
             ($urandom_range(0, 7) == 0), 1'b0);
      end
   endtask

   initial begin
      vif.ce_pix = 0; vif.r_in = 0; vif.g_in = 0; vif.b_in = 0;
      vif.hs_in = 0; vif.vs_in = 0; vif.hblank = 0; vif.vblank = 0;
      vif.scanlines = 0; vif.scan_phase = 0; vif.ypbpr = 0;
      vif.ypbpr_full = 0; vif.csync = 0;
      model_clear();
      do_reset();

      // plain RGB, white with enable gaps
      vsync();
      pix(63, 63, 63); idle(2); pix(63, 63, 63); idle(1); white(2);
      check("rgb_white.r", 32'(vif.r_out), 63);
      check("rgb_white.b", 32'(vif.b_out), 63);
      idle(3);
      check("rgb_hold.g", 32'(vif.g_out), 63);
      random_run(24, 1'b0);
      hsync();
      random_run(16, 1'b0);

      // 50% scanlines on odd lines
      vif.scanlines = 2; vif.scan_phase = 0;
      vsync();
      white(4);
      check("scan_even.r", 32'(vif.r_out), 63);
      hsync(); pix(63, 63, 63); white(4);
      check("scan50.r", 32'(vif.r_out), 31);
      hsync(); pix(63, 63, 63); white(4);
      check("scan_next.r", 32'(vif.r_out), 63);

      // 25% scanlines
      vif.scanlines = 1;
      vsync();
      hsync(); pix(63, 63, 63); white(4);
      check("scan25.g", 32'(vif.g_out), 47);

      // simultaneous sync falls: the phase load wins
      vif.scanlines = 2; vif.scan_phase = 1;
      vsync();
      pix(0, 0, 0, 1, 1, 1, 1);
      pix(0, 0, 0, 0, 0, 1, 1);
      white(4);
      check("both_fall.b", 32'(vif.b_out), 31);
      vif.scanlines = 0; vif.scan_phase = 0;
      vsync();

      // YPbPr request takes effect only at the next frame start
      vif.ypbpr = 1;
      white(4);
      check("mode_wait.g", 32'(vif.g_out), 63);
      vsync();
      white(4);
      check("ypbpr_white.g", 32'(vif.g_out), 58);
      check("ypbpr_white.r", 32'(vif.r_out), 32);
      check("ypbpr_white.b", 32'(vif.b_out), 32);
      repeat (4) pix(63, 0, 0);
      check("ypbpr_red.g", 32'(vif.g_out), 20);
      check("ypbpr_red.b", 32'(vif.b_out), 22);
      check("ypbpr_red.r", 32'(vif.r_out), 59);
      random_run(20, 1'b1);

      // full-range YPbPr
      vif.ypbpr_full = 1;
      vsync();
      repeat (4) pix(63, 0, 0);
      check("full_red.g", 32'(vif.g_out), 19);
      white(4);
      check("full_white.g", 32'(vif.g_out), 63);
      random_run(20, 1'b1);

      // RGB with composite sync
      vif.ypbpr = 0; vif.ypbpr_full = 0; vif.csync = 1;
      vsync();
      random_run(30, 1'b1);

      // reset pulse mid-line, then recovery
      white(3);
      do_reset();
      white(3);
      check("rst_recover3.de", 32'(vif.de_out), 0);
      white(1);
      check("rst_recover4.de", 32'(vif.de_out), 1);
      random_run(20, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
